// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_e;

    localparam int unsigned CNT_W_DEF     = 24;
    localparam int unsigned TICK_DIV_DEF  = 100000;
    localparam int unsigned LAP_DEPTH_DEF = 4;

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Button inputs and display/status outputs of the stopwatch controller.
interface stopwatch_lap_ctrl_if
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned LAP_DEPTH = LAP_DEPTH_DEF
);
    localparam int unsigned LC_W = $clog2(LAP_DEPTH + 1);
    localparam int unsigned VI_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic             btn_start;
    logic             btn_lap;
    logic             btn_clr;
    logic             clear;
    logic             count;
    logic             stop;
    logic [CNT_W-1:0] time_q;
    logic [CNT_W-1:0] disp_q;
    logic [LC_W-1:0]  lap_cnt;
    logic             lap_full;
    logic [VI_W-1:0]  view_idx;
    logic             overflow;

    modport master (
        output btn_start, btn_lap, btn_clr,
        input  clear, count, stop, time_q, disp_q, lap_cnt, lap_full, view_idx, overflow
    );

    modport slave (
        input  btn_start, btn_lap, btn_clr,
        output clear, count, stop, time_q, disp_q, lap_cnt, lap_full, view_idx, overflow
    );

endinterface

// File: rtl/stopwatch_lap_buf.sv
// Lap (split) register file: append-only write port, count/full flags, indexed read.
module stopwatch_lap_buf #(
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       clr,
    input  logic                                       wr_en,
    input  logic [CNT_W-1:0]                           wr_data,
    input  logic [((LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1)-1:0] rd_idx,
    output logic [CNT_W-1:0]                           rd_data_c,
    output logic [$clog2(LAP_DEPTH + 1)-1:0]           lap_cnt,
    output logic                                       lap_full
);
    localparam int unsigned LC_W = $clog2(LAP_DEPTH + 1);
    localparam int unsigned VI_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic [CNT_W-1:0] lap_mem [LAP_DEPTH];

    // Writes are dropped once full so stored laps never change until cleared.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                lap_mem[i] <= '0;
            end
            lap_cnt  <= '0;
            lap_full <= 1'b0;
        end else if (wr_en && !lap_full) begin
            lap_mem[VI_W'(lap_cnt)] <= wr_data;
            lap_cnt  <= lap_cnt + LC_W'(1);
            lap_full <= (lap_cnt + LC_W'(1)) == LC_W'(LAP_DEPTH);
        end
    end

    assign rd_data_c = lap_mem[rd_idx];

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: start/pause/clear FSM, prescaled saturating time counter,
// optional lap buffer with review mode (enabled by STOPWATCH_LAP_EN).
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned TICK_DIV  = TICK_DIV_DEF,
    parameter int unsigned LAP_DEPTH = LAP_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_lap_ctrl_if.slave  bus
);
    localparam int unsigned PS_W = $clog2(TICK_DIV);

    sw_state_e        state, state_nxt;
    logic [PS_W-1:0]  presc, presc_nxt;
    logic [CNT_W-1:0] time_r, time_nxt;
    logic [CNT_W-1:0] disp_r, disp_nxt;
    logic             ovf, ovf_nxt;

    // Next-state, prescaler and saturating time counter.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        time_nxt  = time_r;
        ovf_nxt   = ovf;
        if (bus.btn_clr) begin
            state_nxt = IDLE;
            presc_nxt = '0;
            time_nxt  = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.btn_start) state_nxt = RUN;
                end
                RUN: begin
                    if (presc == PS_W'(TICK_DIV - 1)) begin
                        presc_nxt = '0;
                        if (&time_r) ovf_nxt  = 1'b1;
                        else         time_nxt = time_r + CNT_W'(1);
                    end else begin
                        presc_nxt = presc + PS_W'(1);
                    end
                    if (bus.btn_start) state_nxt = PAUSE;
                end
                PAUSE: begin
                    if (bus.btn_start) state_nxt = RUN;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            presc  <= '0;
            time_r <= '0;
            ovf    <= 1'b0;
            disp_r <= '0;
        end else begin
            state  <= state_nxt;
            presc  <= presc_nxt;
            time_r <= time_nxt;
            ovf    <= ovf_nxt;
            disp_r <= disp_nxt;
        end
    end

    assign bus.clear    = (state == IDLE);
    assign bus.count    = (state == RUN);
    assign bus.stop     = (state == PAUSE);
    assign bus.time_q   = time_r;
    assign bus.disp_q   = disp_r;
    assign bus.overflow = ovf;

`ifdef STOPWATCH_LAP_EN
    localparam int unsigned LC_W = $clog2(LAP_DEPTH + 1);
    localparam int unsigned VI_W = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

    logic             lap_we;
    logic             view_on, view_on_nxt;
    logic [VI_W-1:0]  vidx, vidx_nxt;
    logic [CNT_W-1:0] lap_rd;
    logic [LC_W-1:0]  lap_cnt;
    logic             lap_full;

    // Capture uses the pre-tick time, so a tick in the same cycle is not seen.
    assign lap_we = (state == RUN) && bus.btn_lap && !bus.btn_clr;

    stopwatch_lap_buf #(
        .CNT_W     (CNT_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (bus.btn_clr),
        .wr_en     (lap_we),
        .wr_data   (time_r),
        .rd_idx    (vidx_nxt),
        .rd_data_c (lap_rd),
        .lap_cnt   (lap_cnt),
        .lap_full  (lap_full)
    );

    // Review mode lives only inside PAUSE; any exit drops it.
    always_comb begin
        view_on_nxt = view_on;
        vidx_nxt    = vidx;
        if (bus.btn_clr || bus.btn_start || state != PAUSE) begin
            view_on_nxt = 1'b0;
            vidx_nxt    = '0;
        end else if (bus.btn_lap && lap_cnt != '0) begin
            if (!view_on) begin
                view_on_nxt = 1'b1;
                vidx_nxt    = '0;
            end else if ((LC_W'(vidx) + LC_W'(1)) == lap_cnt) begin
                vidx_nxt    = '0;
            end else begin
                vidx_nxt    = vidx + VI_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            view_on <= 1'b0;
            vidx    <= '0;
        end else begin
            view_on <= view_on_nxt;
            vidx    <= vidx_nxt;
        end
    end

    assign disp_nxt     = view_on_nxt ? lap_rd : time_nxt;
    assign bus.lap_cnt  = lap_cnt;
    assign bus.lap_full = lap_full;
    assign bus.view_idx = vidx;
`else
    logic unused_btn_lap;

    assign unused_btn_lap = bus.btn_lap;
    assign disp_nxt       = time_nxt;
    assign bus.lap_cnt    = '0;
    assign bus.lap_full   = 1'b0;
    assign bus.view_idx   = '0;
`endif

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Bench for stopwatch_lap_ctrl: directed scenarios plus random buttons against a behavioural model.
module tb_stopwatch_lap_ctrl;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned LAP_DEPTH = 2;
    localparam int          CMAX      = (1 << CNT_W) - 1;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    stopwatch_lap_ctrl_if #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) bus ();

    stopwatch_lap_ctrl #(
        .CNT_W     (CNT_W),
        .TICK_DIV  (TICK_DIV),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: mode 0=idle 1=run 2=pause; time derives from cycles spent running.
    int mode = 0;
    int run_cycles = 0;
    int laps[$];
    bit view = 1'b0;
    int vidx = 0;

    function automatic int m_time();
        int t;
        t = run_cycles / int'(TICK_DIV);
        return (t > CMAX) ? CMAX : t;
    endfunction

    function automatic int m_ovf();
        return (run_cycles / int'(TICK_DIV) > CMAX) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        if (reset || bus.btn_clr) begin
            mode = 0; run_cycles = 0; laps.delete(); view = 1'b0; vidx = 0;
        end else begin
            case (mode)
                0: if (bus.btn_start) mode = 1;
                1: begin
                    if (LAP_EN && bus.btn_lap && laps.size() < int'(LAP_DEPTH))
                        laps.push_back(m_time());
                    run_cycles++;
                    if (bus.btn_start) mode = 2;
                end
                default: begin
                    if (bus.btn_start) begin
                        mode = 1; view = 1'b0; vidx = 0;
                    end else if (LAP_EN && bus.btn_lap && laps.size() > 0) begin
                        if (!view) begin
                            view = 1'b1; vidx = 0;
                        end else begin
                            vidx = (vidx + 1) % laps.size();
                        end
                    end
                end
            endcase
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            int t;
            int ed;
            t  = m_time();
            ed = view ? laps[vidx] : t;
            chk("clear",    int'(bus.clear),    (mode == 0) ? 1 : 0);
            chk("count",    int'(bus.count),    (mode == 1) ? 1 : 0);
            chk("stop",     int'(bus.stop),     (mode == 2) ? 1 : 0);
            chk("time_q",   int'(bus.time_q),   t);
            chk("disp_q",   int'(bus.disp_q),   ed);
            chk("lap_cnt",  int'(bus.lap_cnt),  laps.size());
            chk("lap_full", int'(bus.lap_full), (laps.size() == int'(LAP_DEPTH)) ? 1 : 0);
            chk("view_idx", int'(bus.view_idx), vidx);
            chk("overflow", int'(bus.overflow), m_ovf());
        end
    end

    task automatic cyc(input bit s, input bit l, input bit c);
        bus.btn_start = s; bus.btn_lap = l; bus.btn_clr = c;
        @(negedge clk);
        bus.btn_start = 1'b0; bus.btn_lap = 1'b0; bus.btn_clr = 1'b0;
    endtask

    task automatic run_to(input int tgt);
        for (int i = 0; i < 200 && m_time() < tgt; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int tg[3];
        tg[0] = 2; tg[1] = 5; tg[2] = 7;
        reset = 1'b1;
        bus.btn_start = 1'b0; bus.btn_lap = 1'b0; bus.btn_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Idle after reset.
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        chk("idle_clear", int'(bus.clear), 1);
        chk("idle_count", int'(bus.count), 0);
        chk("idle_time",  int'(bus.time_q), 0);

        // Start, 12 cycles, pause: 13 running edges give 3 ticks.
        cyc(1'b1, 1'b0, 1'b0);
        chk("run_count", int'(bus.count), 1);
        repeat (12) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("pause_time", int'(bus.time_q), 3);
        chk("pause_stop", int'(bus.stop), 1);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        chk("hold_time", int'(bus.time_q), 3);

        // Laps at 2, 5, 7; the third one finds the buffer full.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            run_to(tg[k]);
            chk("lap_at_time", int'(bus.time_q), tg[k]);
            cyc(1'b0, 1'b1, 1'b0);
        end
        chk("laps_cnt",  int'(bus.lap_cnt),  LAP_EN ? 2 : 0);
        chk("laps_full", int'(bus.lap_full), LAP_EN ? 1 : 0);

        // Review: 2, 5, 2 then resume.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("view0_disp", int'(bus.disp_q),   LAP_EN ? 2 : m_time());
        chk("view0_idx",  int'(bus.view_idx), 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("view1_disp", int'(bus.disp_q),   LAP_EN ? 5 : m_time());
        chk("view1_idx",  int'(bus.view_idx), LAP_EN ? 1 : 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("view2_disp", int'(bus.disp_q),   LAP_EN ? 2 : m_time());
        chk("view2_idx",  int'(bus.view_idx), 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("resume_idx",  int'(bus.view_idx), 0);
        chk("resume_disp", int'(bus.disp_q),   m_time());

        // Saturation, then clear back to reset values.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 1300 && m_ovf() == 0; i++) cyc(1'b0, 1'b0, 1'b0);
        repeat (10) cyc(1'b0, 1'b0, 1'b0);
        chk("sat_time", int'(bus.time_q),   255);
        chk("sat_ovf",  int'(bus.overflow), 1);
        cyc(1'b0, 1'b0, 1'b1);
        chk("clr_clear", int'(bus.clear),    1);
        chk("clr_time",  int'(bus.time_q),   0);
        chk("clr_disp",  int'(bus.disp_q),   0);
        chk("clr_ovf",   int'(bus.overflow), 0);

        // Start+lap in the same RUN cycle at time 4.
        cyc(1'b1, 1'b0, 1'b0);
        run_to(4);
        chk("combo_pre", int'(bus.time_q), 4);
        cyc(1'b1, 1'b1, 1'b0);
        chk("combo_stop", int'(bus.stop),    1);
        chk("combo_cnt",  int'(bus.lap_cnt), LAP_EN ? 1 : 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("combo_disp", int'(bus.disp_q), 4);

        // Clear with lap pressed mid-run captures nothing.
        cyc(1'b1, 1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("clrlap_cnt",   int'(bus.lap_cnt), 0);
        chk("clrlap_clear", int'(bus.clear),   1);

        // Random button traffic.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 399) == 0);
            cyc($urandom_range(0, 14) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 149) == 0);
            reset = 1'b0;
        end
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
